// File: rtl/lane_log_scroller_if.sv
// Bus bundle for lane_log_scroller: lane control, frog query and log outputs.
interface lane_log_scroller_if #(
  parameter int NUM_LANES     = 4,
  parameter int LOGS_PER_LANE = 2,
  parameter int X_W           = 11
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                                   run;
  logic [NUM_LANES-1:0]                   lane_dir;
  logic [4*NUM_LANES-1:0]                 lane_speed;
  logic                                   frog_valid;
  logic [LANE_W-1:0]                      frog_lane;
  logic signed [X_W-1:0]                  frog_x;
  logic                                   tick;
  logic [X_W*NUM_LANES*LOGS_PER_LANE-1:0] log_x;
  logic                                   on_log;
  logic signed [X_W-1:0]                  carry_dx;
  logic                                   resp_valid;

  modport master (
    output run, lane_dir, lane_speed, frog_valid, frog_lane, frog_x,
    input  tick, log_x, on_log, carry_dx, resp_valid
  );

  modport slave (
    input  run, lane_dir, lane_speed, frog_valid, frog_lane, frog_x,
    output tick, log_x, on_log, carry_dx, resp_valid
  );
endinterface

// File: rtl/lane_log_scroller.sv
// Multi-lane river log mover: prescaled movement tick, per-lane direction and
// speed with off-screen wrap, and a registered frog-on-log query.
module lane_log_scroller #(
  parameter int NUM_LANES     = 4,
  parameter int LOGS_PER_LANE = 2,
  parameter int BLOCK         = 32,
  parameter int LOG_BLOCKS    = 3,
  parameter int SCREEN_W      = 320,
  parameter int TICK_DIV      = 262144,
  parameter int X_W           = 11
) (
  input logic               clk,
  input logic               reset,
  lane_log_scroller_if.slave bus
);
  localparam int LOG_W  = LOG_BLOCKS * BLOCK;
  localparam int SP     = (SCREEN_W + LOG_W) / LOGS_PER_LANE;
  localparam int NLOGS  = NUM_LANES * LOGS_PER_LANE;
  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic signed [X_W-1:0] SCR_X  = X_W'(SCREEN_W);
  localparam logic signed [X_W-1:0] NEG_LW = X_W'(-LOG_W);
  localparam logic signed [X_W-1:0] LW_X   = X_W'(LOG_W);
  localparam logic signed [X_W-1:0] HALF   = X_W'(BLOCK / 2);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]      count;
  logic                  tick_r;
  logic signed [X_W-1:0] pos      [NLOGS];
  logic signed [X_W-1:0] next_pos [NLOGS];
  logic signed [X_W-1:0] spd      [NUM_LANES];
  logic signed [X_W-1:0] centre;
  logic                  hit;
  logic signed [X_W-1:0] sel_dx;
  logic                  on_log_r;
  logic                  resp_r;
  logic signed [X_W-1:0] carry_r;
  logic [X_W*NLOGS-1:0]  log_flat;

  assign centre = bus.frog_x + HALF;

  // Prescaler: counts only while running; tick is the registered terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      tick_r <= 1'b0;
    end else if (bus.run) begin
      if (count == CNT_MAX) begin
        count  <= '0;
        tick_r <= 1'b1;
      end else begin
        count  <= count + CNT_W'(1);
        tick_r <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  // Zero-extend each lane's 4-bit speed into the coordinate width.
  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      spd[l] = {{(X_W-4){1'b0}}, bus.lane_speed[4*l +: 4]};
    end
  end

  // Candidate positions after one movement step, wrapping without overshoot.
  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      for (int unsigned j = 0; j < LOGS_PER_LANE; j++) begin
        if (bus.lane_dir[l]) begin
          next_pos[l*LOGS_PER_LANE + j] =
            (pos[l*LOGS_PER_LANE + j] + spd[l] >= SCR_X) ? NEG_LW
                                                         : pos[l*LOGS_PER_LANE + j] + spd[l];
        end else begin
          next_pos[l*LOGS_PER_LANE + j] =
            (pos[l*LOGS_PER_LANE + j] - spd[l] <= NEG_LW) ? SCR_X
                                                          : pos[l*LOGS_PER_LANE + j] - spd[l];
        end
      end
    end
  end

  // Log position registers: spawn spacing on reset, step on each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        for (int unsigned j = 0; j < LOGS_PER_LANE; j++) begin
          pos[l*LOGS_PER_LANE + j] <= X_W'(int'(j) * SP - LOG_W);
        end
      end
    end else if (tick_r) begin
      pos <= next_pos;
    end
  end

  // Hit test of the frog centre against the queried lane's logs; an
  // out-of-range lane matches no loop index and so never hits.
  always_comb begin
    hit    = 1'b0;
    sel_dx = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (bus.frog_lane == LANE_W'(l)) begin
        sel_dx = bus.lane_dir[l] ? spd[l] : -spd[l];
        for (int unsigned j = 0; j < LOGS_PER_LANE; j++) begin
          if ((pos[l*LOGS_PER_LANE + j] <= centre) &&
              (centre < pos[l*LOGS_PER_LANE + j] + LW_X)) begin
            hit = 1'b1;
          end
        end
      end
    end
  end

  // Query response register: results hold between queries.
  always_ff @(posedge clk) begin
    if (reset) begin
      on_log_r <= 1'b0;
      carry_r  <= '0;
      resp_r   <= 1'b0;
    end else begin
      resp_r <= bus.frog_valid;
      if (bus.frog_valid) begin
        on_log_r <= hit;
        carry_r  <= (hit && tick_r) ? sel_dx : '0;
      end
    end
  end

  // Flatten the position array onto the output bus.
  always_comb begin
    log_flat = '0;
    for (int unsigned k = 0; k < NLOGS; k++) begin
      log_flat[k*X_W +: X_W] = pos[k];
    end
  end

  assign bus.tick       = tick_r;
  assign bus.log_x      = log_flat;
  assign bus.on_log     = on_log_r;
  assign bus.carry_dx   = carry_r;
  assign bus.resp_valid = resp_r;
endmodule
